// File: rtl/add_pkg.sv
// Shared constants and types for the adder result path.
package add_pkg;

    // Adder operand width 4 plus its carry-out.
    localparam int ADD_SUM_W = 5;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add of a zero-extended addend onto an accumulator.
module sat_add #(
    parameter int ACC_W = 8,
    parameter int IN_W  = 5
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] wide;

    assign wide = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, addend};
    assign ovf  = wide[ACC_W];
    assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/add_result_acc.sv
// Accumulates blocks of N_SAMPLES adder sums into a saturating total and
// presents each block total on a registered valid/ready output.
module add_result_acc
    import add_pkg::*;
#(
    parameter int IN_W      = ADD_SUM_W,
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [IN_W-1:0]  sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             res_valid,
    input  logic             res_ready
);

    acc_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             res_valid_reg, res_valid_next;
    logic [ACC_W-1:0] res_data_reg, res_data_next;
    logic             res_ovf_reg, res_ovf_next;

    logic [ACC_W-1:0] sat_sum;
    logic             sat_ovf;
    logic             accept;

    sat_add #(
        .ACC_W (ACC_W),
        .IN_W  (IN_W)
    ) u_sat_add (
        .acc    (acc_reg),
        .addend (sum_in),
        .sum    (sat_sum),
        .ovf    (sat_ovf)
    );

    assign sum_ready = rst_n && (state_reg == ACCUM) && !clr;
    assign accept    = sum_valid && sum_ready;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        res_ovf_next   = res_ovf_reg;

        if (clr) begin
            // Abort: any pending result is dropped, last delivered data kept.
            state_next     = ACCUM;
            acc_next       = '0;
            cnt_next       = '0;
            ovf_next       = 1'b0;
            res_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        acc_next = sat_sum;
                        ovf_next = ovf_reg | sat_ovf;
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(N_SAMPLES - 1)) begin
                            res_data_next  = sat_sum;
                            res_ovf_next   = ovf_reg | sat_ovf;
                            res_valid_next = 1'b1;
                            state_next     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_next = 1'b0;
                        acc_next       = '0;
                        cnt_next       = '0;
                        ovf_next       = 1'b0;
                        state_next     = ACCUM;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_ovf_reg   <= res_ovf_next;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_ovf   = res_ovf_reg;

endmodule

// File: tb/tb_add_result_acc.sv
// Directed vector bench for add_result_acc: default, narrow-accumulator and
// single-sample instances share stimulus; each vector checks one instance.
module tb_add_result_acc;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [4:0] sum_in;
    logic       sum_valid;
    logic       res_ready;

    logic       rdy_a, rv_a, ovf_a;
    logic [7:0] data_a;
    logic       rdy_b, rv_b, ovf_b;
    logic [5:0] data_b;
    logic       rdy_c, rv_c, ovf_c;
    logic [7:0] data_c;

    int n_checks = 0;
    int n_errors = 0;

    add_result_acc u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(rdy_a), .res_data(data_a), .res_ovf(ovf_a), .res_valid(rv_a),
        .res_ready(res_ready)
    );

    add_result_acc #(.ACC_W(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(rdy_b), .res_data(data_b), .res_ovf(ovf_b), .res_valid(rv_b),
        .res_ready(res_ready)
    );

    add_result_acc #(.N_SAMPLES(1), .CNT_W(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(rdy_c), .res_data(data_c), .res_ovf(ovf_c), .res_valid(rv_c),
        .res_ready(res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // chk: 0 = sum_ready only, 1 = plus res_valid, 2 = plus res_data/res_ovf
    typedef struct {
        int dut;
        int rst_n;
        int clr;
        int sv;
        int sum;
        int rr;
        int chk;
        int rdy;
        int rv;
        int data;
        int ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input int dut, input int rn, input int cl, input int sv, input int sm,
                     input int rr, input int chk, input int rdy, input int rv,
                     input int data, input int ovf);
        vec_t e;
        e.dut = dut; e.rst_n = rn; e.clr = cl; e.sv = sv; e.sum = sm; e.rr = rr;
        e.chk = chk; e.rdy = rdy; e.rv = rv; e.data = data; e.ovf = ovf;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL vec%0d %s got %0d want %0d", idx, name, got, want);
        end
    endtask

    initial begin
        logic [31:0] g_rdy, g_rv, g_data, g_ovf;
        int waited;

        rst_n = 1'b0; clr = 1'b0; sum_valid = 1'b0; sum_in = '0; res_ready = 1'b0;

        // Instance A: default parameters
        v(0,0,0,0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0,2,0,0,0,0);
        v(0,1,0,1,5,1,2,1,0,0,0);
        v(0,1,0,1,21,1,2,1,0,0,0);
        v(0,1,0,1,17,1,2,1,0,0,0);
        v(0,1,0,1,8,1,2,1,0,0,0);
        v(0,1,0,0,0,1,2,0,1,51,0);
        v(0,1,0,0,0,0,2,1,0,51,0);
        // gaps and backpressure
        v(0,1,0,1,5,0,2,1,0,51,0);
        v(0,1,0,0,0,0,2,1,0,51,0);
        v(0,1,0,1,21,0,2,1,0,51,0);
        v(0,1,0,0,0,0,2,1,0,51,0);
        v(0,1,0,1,17,0,2,1,0,51,0);
        v(0,1,0,1,8,0,2,1,0,51,0);
        for (int k = 0; k < 5; k++) v(0,1,0,1,9,0,2,0,1,51,0);
        v(0,1,0,0,0,1,2,0,1,51,0);
        v(0,1,0,0,0,0,2,1,0,51,0);
        // clr mid-block, then clr during HOLD
        v(0,1,0,1,10,0,2,1,0,51,0);
        v(0,1,0,1,10,0,2,1,0,51,0);
        v(0,1,1,1,7,0,2,0,0,51,0);
        v(0,1,0,1,1,0,2,1,0,51,0);
        v(0,1,0,1,2,0,2,1,0,51,0);
        v(0,1,0,1,3,0,2,1,0,51,0);
        v(0,1,0,1,4,0,2,1,0,51,0);
        v(0,1,0,0,0,0,2,0,1,10,0);
        v(0,1,1,0,0,0,2,0,1,10,0);
        v(0,1,0,0,0,0,1,1,0,0,0);
        for (int k = 0; k < 4; k++) v(0,1,0,1,2,0,1,1,0,0,0);
        v(0,1,0,0,0,1,2,0,1,8,0);
        v(0,1,0,0,0,0,2,1,0,8,0);
        // reset mid-block
        for (int k = 0; k < 3; k++) v(0,1,0,1,1,0,2,1,0,8,0);
        v(0,0,0,1,3,0,2,0,0,8,0);
        v(0,0,0,1,3,0,2,0,0,0,0);
        v(0,1,0,1,3,0,2,1,0,0,0);
        for (int k = 0; k < 3; k++) v(0,1,0,1,3,0,2,1,0,0,0);
        v(0,1,0,0,0,0,2,0,1,12,0);
        v(0,1,0,0,0,1,2,0,1,12,0);
        v(0,1,0,0,0,0,2,1,0,12,0);

        // Instance B: ACC_W=6 saturation
        v(1,0,0,0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0,2,0,0,0,0);
        for (int k = 0; k < 3; k++) v(1,1,0,1,31,0,2,1,0,0,0);
        v(1,1,0,1,2,0,2,1,0,0,0);
        v(1,1,0,0,0,1,2,0,1,63,1);
        for (int k = 0; k < 4; k++) v(1,1,0,1,1,0,2,1,0,63,1);
        v(1,1,0,0,0,1,2,0,1,4,0);
        v(1,1,0,0,0,0,2,1,0,4,0);

        // Instance C: N_SAMPLES=1
        v(2,0,0,0,0,0,0,0,0,0,0);
        v(2,0,0,0,0,0,2,0,0,0,0);
        v(2,1,0,1,9,1,2,1,0,0,0);
        v(2,1,0,1,30,1,2,0,1,9,0);
        v(2,1,0,1,30,1,2,1,0,9,0);
        v(2,1,0,0,0,1,2,0,1,30,0);
        v(2,1,0,0,0,1,2,1,0,30,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n     = (vecs[i].rst_n != 0);
            clr       = (vecs[i].clr != 0);
            sum_valid = (vecs[i].sv != 0);
            sum_in    = 5'(vecs[i].sum);
            res_ready = (vecs[i].rr != 0);
            #1;
            case (vecs[i].dut)
                0:       begin g_rdy = 32'(rdy_a); g_rv = 32'(rv_a); g_data = 32'(data_a); g_ovf = 32'(ovf_a); end
                1:       begin g_rdy = 32'(rdy_b); g_rv = 32'(rv_b); g_data = 32'(data_b); g_ovf = 32'(ovf_b); end
                default: begin g_rdy = 32'(rdy_c); g_rv = 32'(rv_c); g_data = 32'(data_c); g_ovf = 32'(ovf_c); end
            endcase
            check("sum_ready", i, g_rdy, 32'(vecs[i].rdy));
            if (vecs[i].chk >= 1) check("res_valid", i, g_rv, 32'(vecs[i].rv));
            if (vecs[i].chk >= 2) begin
                check("res_data", i, g_data, 32'(vecs[i].data));
                check("res_ovf", i, g_ovf, 32'(vecs[i].ovf));
            end
            $display("vec%0d dut%0d rst_n=%0d clr=%0d sv=%0d sum=%0d rr=%0d -> rdy=%0d rv=%0d data=%0d ovf=%0d",
                     i, vecs[i].dut, vecs[i].rst_n, vecs[i].clr, vecs[i].sv, vecs[i].sum,
                     vecs[i].rr, g_rdy, g_rv, g_data, g_ovf);
        end

        // Final-accept-to-valid latency and single bubble on instance A
        @(negedge clk);
        rst_n = 1'b0; clr = 1'b0; sum_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; sum_valid = 1'b1; sum_in = 5'd1;
        repeat (4) @(negedge clk);
        sum_valid = 1'b0;
        waited = 0;
        while (!rv_a && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("latency", 0, 32'(waited + 1), 32'd1);
        check("lat_data", 0, 32'(data_a), 32'd4);
        $display("latency seq: cycles=%0d data=%0d", waited + 1, data_a);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("bubble_ready", 0, 32'(rdy_a), 32'd1);
        check("bubble_valid", 0, 32'(rv_a), 32'd0);
        $display("release seq: rdy=%0d rv=%0d", rdy_a, rv_a);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
